// File: rtl/mac_slice_acc.sv
// Bit-serial MAC slice: LANES 1-bit activations times WBITS weights.
// Each frame is XBITS bit-planes (LSB first), accumulated into an ACC_W result.
module mac_slice_acc #(
    parameter  int LANES    = 256,
    parameter  int WBITS    = 4,
    parameter  int XBITS    = 4,
    parameter  int W_SIGNED = 0,
    localparam int ACC_W    = WBITS + XBITS + $clog2(LANES),
    localparam int KW       = (XBITS > 1) ? $clog2(XBITS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   w_load,
    input  logic [LANES*WBITS-1:0] w_data,
    output logic                   w_err,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES-1:0]       in_bits,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_data
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

    state_t                 state_q, state_d;
    logic [LANES*WBITS-1:0] weights_q, weights_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [KW-1:0]          beat_q, beat_d;
    logic [ACC_W-1:0]       part_q, part_d;
    logic [KW-1:0]          part_k_q, part_k_d;
    logic                   part_vld_q, part_vld_d;
    logic                   w_err_q, w_err_d;

    logic [ACC_W-1:0]       partial;
    logic [WBITS-1:0]       lane_w;
    logic [ACC_W-1:0]       lane_ext;
    logic                   accept;

    assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign out_valid = (state_q == OUT);
    assign out_data  = acc_q;
    assign w_err     = w_err_q;
    assign accept    = in_valid && in_ready;

    // Sum of weights for lanes whose activation bit is set in this plane
    always_comb begin
        partial  = '0;
        lane_w   = '0;
        lane_ext = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_w = weights_q[WBITS*i +: WBITS];
            if (W_SIGNED != 0)
                lane_ext = {{(ACC_W-WBITS){lane_w[WBITS-1]}}, lane_w};
            else
                lane_ext = {{(ACC_W-WBITS){1'b0}}, lane_w};
            if (in_bits[i])
                partial = partial + lane_ext;
        end
    end

    // Frame FSM, weight load, partial pipeline and shifted accumulate
    always_comb begin
        state_d    = state_q;
        weights_d  = weights_q;
        acc_d      = acc_q;
        beat_d     = beat_q;
        part_d     = part_q;
        part_k_d   = part_k_q;
        part_vld_d = 1'b0;
        w_err_d    = 1'b0;

        // Partial registered last edge lands in the accumulator now
        if (part_vld_q)
            acc_d = acc_q + (part_q << part_k_q);

        case (state_q)
            IDLE: begin
                if (w_load)
                    weights_d = w_data;
                if (accept) begin
                    acc_d      = '0;
                    part_d     = partial;
                    part_k_d   = '0;
                    part_vld_d = 1'b1;
                    if (XBITS == 1) begin
                        state_d = DRAIN;
                    end else begin
                        beat_d  = KW'(1);
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                w_err_d = w_load;
                if (accept) begin
                    part_d     = partial;
                    part_k_d   = beat_q;
                    part_vld_d = 1'b1;
                    if (beat_q == KW'(XBITS-1))
                        state_d = DRAIN;
                    else
                        beat_d = beat_q + KW'(1);
                end
            end
            DRAIN: begin
                w_err_d = w_load;
                // Leave only once the final partial has been folded in
                if (!part_vld_q)
                    state_d = OUT;
            end
            OUT: begin
                w_err_d = w_load;
                if (out_ready) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            weights_q  <= '0;
            acc_q      <= '0;
            beat_q     <= '0;
            part_q     <= '0;
            part_k_q   <= '0;
            part_vld_q <= 1'b0;
            w_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            weights_q  <= weights_d;
            acc_q      <= acc_d;
            beat_q     <= beat_d;
            part_q     <= part_d;
            part_k_q   <= part_k_d;
            part_vld_q <= part_vld_d;
            w_err_q    <= w_err_d;
        end
    end

endmodule

// File: doc/mac_slice_acc.md
MAC_SLICE_ACC -- requirements
Module: mac_slice_acc

Interface
REQ-001 SHALL have parameter LANES, 256, number of 1-bit input lanes / weights.
REQ-002 SHALL have parameter WBITS, 4, weight width per lane.
REQ-003 SHALL have parameter XBITS, 4, activation precision; one frame is XBITS bit-serial beats.
REQ-004 SHALL have parameter W_SIGNED, 0, 1 = weights two's complement, 0 = unsigned.
REQ-005 SHALL derive ACC_W = WBITS + XBITS + clog2(LANES), the result width.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 w_load  input  1  weight-load strobe.
REQ-009 w_data  input  LANES*WBITS  flattened weights; lane i at [WBITS*i +: WBITS].
REQ-010 w_err  output  1  one-cycle pulse: w_load rejected.
REQ-011 in_valid  input  1  beat valid.
REQ-012 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-013 in_bits  input  LANES  one bit-plane of all lane activations, LSB plane first.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-016 out_data  output  ACC_W  frame dot product; signed when W_SIGNED=1.

Function
REQ-017 SHALL hold weights in an internal LANES*WBITS register, loaded from w_data on a clk edge with w_load=1 in IDLE only.
REQ-018 w_load=1 in any state other than IDLE SHALL leave weights unchanged and pulse w_err for exactly one cycle.
REQ-019 SHALL implement states IDLE, ACCUM, DRAIN, OUT.
REQ-020 IDLE -> ACCUM on first accepted beat; accumulator cleared to 0 at that edge, beat index set to 0.
REQ-021 ACCUM: each accepted beat k (k = 0..XBITS-1) SHALL register partial_k = sum over lanes of (in_bits[i] ? weight_i : 0), weights sign-extended to ACC_W when W_SIGNED=1, zero-extended otherwise.
REQ-022 Each registered partial_k SHALL be added to the accumulator as (partial_k << k) on the clk edge after it is registered (one pipeline stage).
REQ-023 ACCUM -> DRAIN on acceptance of beat XBITS-1; DRAIN -> OUT after the final partial is accumulated.
REQ-024 in_ready SHALL be 1 in IDLE and ACCUM, 0 in DRAIN and OUT.
REQ-025 out_valid SHALL be 1 exactly in OUT; out_data SHALL be the accumulator and stable while out_valid && !out_ready.
REQ-026 Latency: out_valid SHALL first be high in the cycle two clk edges after the edge that accepts beat XBITS-1.
REQ-027 OUT -> IDLE on out_valid && out_ready; out_data SHALL keep last value in IDLE.
REQ-028 in_valid=0 in ACCUM SHALL stall without losing state; beats need not be contiguous.
REQ-029 Arithmetic SHALL be exact modulo 2^ACC_W; no saturation; ACC_W provably covers full-scale results.
REQ-030 Accepted beats never exceed XBITS per frame; beat index SHALL wrap to 0 only through IDLE.

Reset
REQ-031 rst=1 at a clk edge SHALL force IDLE, accumulator 0, beat index 0, pipeline partial 0, out_data 0, out_valid 0, w_err 0; in_ready 1 after reset.
REQ-032 Weight register SHALL reset to all zeros.
REQ-033 rst mid-frame or in OUT SHALL discard the frame; no out_valid for it.
REQ-034 rst has priority over w_load, in_valid and out_ready on the same edge.

Verification
REQ-035 Defaults, W_SIGNED=0, all weights 15, 4 beats in_bits all-ones, out_ready=1 -> out_data 57600, out_valid two edges after 4th beat, 1 cycle wide.
REQ-036 W_SIGNED=1, all weights 4'b1000 (-8), 4 all-ones beats -> out_data -30720 (16'h8800).
REQ-037 Lane 0 weight 5, others 0; beats in_bits[0] = 1,0,1,0 (x=5), in_valid gaps between beats -> out_data 25.
REQ-038 out_ready=0 for 5 cycles in OUT -> out_valid, out_data held; in_ready 0; w_load there -> w_err pulse, weights unchanged.
REQ-039 rst asserted after 2 beats of a frame -> all outputs at reset values next cycle; following full frame result unaffected by discarded beats.
REQ-040 Back-to-back frames with out_ready=1 -> second frame's first beat accepted the cycle after handshake; both results correct.
